fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch initiator for the QUAD.nibble core; sole reader of progmem.
- Drives the progmem word address and absorbs its 1-cycle registered read latency.
- Buffers fetched 16-bit instructions in a small FIFO and presents them to decode with a valid/ready handshake.
- Supports branch/jump redirect (flush) and halt (stop issuing, drain).

Parameters:
- ADDR_W, 16, PC / progmem address width (word-addressed).
- INSTR_W, 16, instruction width (matches progmem data width).
- DEPTH, 2, instruction FIFO entries; must be ≥2 for 1 instr/cycle throughput.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- pm_addr  out  ADDR_W  progmem address (registered fetch PC).
- pm_rdata  in  INSTR_W  progmem dout; valid the cycle after an address is presented.
- pm_wdata  out  INSTR_W  constant 0.
- pm_we  out  1  constant 0; this block never writes.
- instr  out  INSTR_W  FIFO head instruction.
- instr_pc  out  ADDR_W  address of instr.
- instr_valid  out  1  FIFO non-empty.
- instr_ready  in  1  decode accepts head.
- redirect_valid  in  1  flush and restart at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address.
- halt  in  1  suppress new fetch issue.

Behaviour:
- Reset (async, resetn=0):
  - fetch_pc=RESET_PC, so pm_addr=RESET_PC.
  - in_flight=0, FIFO empty, instr_valid=0, instr=0, instr_pc=0.
  - pm_we=0 and pm_wdata=0 at all times.
- State:
  - fetch_pc: next address to issue.
  - in_flight flag plus inflight_pc: a read was issued last cycle.
  - FIFO of {instr, pc} with count 0..DEPTH.
- pop = instr_valid & instr_ready & ~redirect_valid. A handshake in a redirect cycle does not transfer.
- issue = ~redirect_valid & ~halt & ((count + in_flight − pop) < DEPTH).
  - On issue: in_flight<=1, inflight_pc<=fetch_pc, fetch_pc<=fetch_pc+1 (mod 2^ADDR_W; 16'hFFFF→16'h0000).
  - Otherwise: in_flight<=0 and fetch_pc holds.
- Completion: if in_flight=1 and no redirect this cycle, push {pm_rdata, inflight_pc} at this clock edge.
  - Push and pop may occur in the same cycle.
  - The issue rule guarantees push never overflows.
- Latency: address issued in cycle F, data sampled in F+1, instr_valid=1 in F+2.
  - Steady state with instr_ready=1 is 1 instr/cycle, sequential PCs.
- Redirect in cycle N (highest priority):
  - FIFO flushed (count<=0), in_flight<=0; the data arriving in N+1 is discarded.
  - fetch_pc<=redirect_pc. First issue is in N+1; instr_valid with instr_pc=redirect_pc in N+3.
  - instr_valid is 0 in N+1 and N+2.
  - A redirect during halt loads fetch_pc but issues nothing until halt=0.
- Halt:
  - No new issue; any in-flight read completes and is pushed.
  - The FIFO drains normally; pm_addr holds.
  - Deasserting halt resumes issue at fetch_pc the same cycle.
- Empty/full:
  - instr_valid = (count≠0).
  - When count=DEPTH and instr_ready=0, no issue; fetch_pc and pm_addr hold.
  - No instruction is lost or duplicated.
- Reset mid-operation: all state cleared immediately. progmem dout also resets to 0, but in_flight=0 so nothing is pushed.

Decomposition:
- Shared package quad_pkg:
  - typedef addr_t (logic [15:0]).
  - typedef instr_t (logic [15:0]).
  - RESET_PC constant.
  - fetch_entry_t struct {instr_t instr; addr_t pc}.
- One sub-module, fetch_fifo: parameterised-depth synchronous FIFO of fetch_entry_t with push, pop, synchronous flush, count, and async active-low reset.
- fetch_unit keeps the PC, in-flight tracking and issue logic.

Test Plan:
- Reset/stream: mem[0..3]=16'hA000..16'hA003, instr_ready=1, release resetn → instr_valid first in cycle 2 after release; (instr,pc)=(A000,0),(A001,1),(A002,2),(A003,3) on consecutive cycles.
- Backpressure: instr_ready=0 from the first valid → count reaches 2, issue stops, pm_addr holds 16'h0002; then instr_ready=1 → pcs 0,1,2,3 in order with no gaps after refill and no duplicates.
- Redirect with full FIFO plus in-flight read: redirect_pc=16'h0100 in cycle N → instr_valid=0 in N+1..N+2; N+3 instr_pc=16'h0100, then 16'h0101; stale pcs never appear.
- Wrap: redirect to 16'hFFFF, mem[FFFF]=16'h1111, mem[0]=16'h2222 → instr_pc sequence FFFF, 0000 with matching data.
- Halt: halt=1 mid-stream → at most one further push, FIFO drains, instr_valid drops, pm_addr constant; halt=0 → stream resumes at the next sequential pc.
- Async reset mid-stream with FIFO full → instr_valid=0 and pm_addr=RESET_PC without a clock edge; after release the sequence restarts at pc 0.

Source files
------------

// File: rtl/quad_pkg.sv
// Shared types for the QUAD.nibble core: word addresses, instructions and
// the {instr, pc} entry the fetch unit hands to decode.
package quad_pkg;

   localparam int ADDR_W      = 16;
   localparam int INSTR_W     = 16;
   localparam int FETCH_DEPTH = 2;

   typedef logic [ADDR_W-1:0]  addr_t;
   typedef logic [INSTR_W-1:0] instr_t;

   localparam addr_t RESET_PC = 16'h0000;

   typedef struct packed {
      instr_t instr;
      addr_t  pc;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit signal bundle: progmem read port, decode handshake and the
// redirect/halt controls. The fetch unit is the master side.
interface fetch_unit_if #(
   parameter int ADDR_W  = quad_pkg::ADDR_W,
   parameter int INSTR_W = quad_pkg::INSTR_W
);

   logic [ADDR_W-1:0]  pm_addr;
   logic [INSTR_W-1:0] pm_rdata;
   logic [INSTR_W-1:0] pm_wdata;
   logic               pm_we;

   logic [INSTR_W-1:0] instr;
   logic [ADDR_W-1:0]  instr_pc;
   logic               instr_valid;
   logic               instr_ready;

   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_pc;
   logic               halt;

   modport master (
      output pm_addr, pm_wdata, pm_we, instr, instr_pc, instr_valid,
      input  pm_rdata, instr_ready, redirect_valid, redirect_pc, halt
   );

   modport slave (
      input  pm_addr, pm_wdata, pm_we, instr, instr_pc, instr_valid,
      output pm_rdata, instr_ready, redirect_valid, redirect_pc, halt
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// The head reads as zero whenever the FIFO is empty.
module fetch_fifo
   import quad_pkg::*;
#(
   parameter int DEPTH = FETCH_DEPTH,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               flush,
   input  logic               push,
   input  fetch_entry_t       push_data,
   input  logic               pop,
   output fetch_entry_t       head,
   output logic [CNT_W-1:0]   count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_en;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign push_en = push & ~flush;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)     rd_ptr_d = ptr_inc(rd_ptr_q);
         case ({push_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is not reset; stale entries are unreachable because the head is masked by count.
   always_ff @(posedge clk) begin
      if (push_en) mem_q[wr_ptr_q] <= push_data;
   end

   assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: issues progmem reads, absorbs the 1-cycle
// read latency and queues {instr, pc} for decode; handles redirect and halt.
module fetch_unit
   import quad_pkg::*;
#(
   parameter int    DEPTH    = FETCH_DEPTH,
   parameter addr_t RESET_PC = quad_pkg::RESET_PC
) (
   input  logic          clk,
   input  logic          resetn,
   fetch_unit_if.master  bus
);

   localparam int CNT_W = $clog2(DEPTH + 1);

   addr_t            fetch_pc_q, fetch_pc_d;
   addr_t            inflight_pc_q, inflight_pc_d;
   logic             in_flight_q, in_flight_d;

   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occupancy;
   fetch_entry_t     head;
   fetch_entry_t     push_entry;
   logic             instr_valid;
   logic             pop;
   logic             push;
   logic             issue;

   always_comb begin
      instr_valid = (count != '0);
      pop         = instr_valid & bus.instr_ready & ~bus.redirect_valid;
      push        = in_flight_q & ~bus.redirect_valid;
      // Slots already claimed once this cycle's pop retires; the in-flight
      // read must always have a free entry waiting for it.
      occupancy   = {1'b0, count} + (CNT_W+1)'(in_flight_q) - (CNT_W+1)'(pop);
      issue       = ~bus.redirect_valid & ~bus.halt & (occupancy < (CNT_W+1)'(DEPTH));

      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      in_flight_d   = issue;
      if (bus.redirect_valid) begin
         fetch_pc_d = bus.redirect_pc;
      end else if (issue) begin
         fetch_pc_d    = fetch_pc_q + 1'b1;
         inflight_pc_d = fetch_pc_q;
      end

      push_entry = '{instr: bus.pm_rdata, pc: inflight_pc_q};
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         in_flight_q   <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         in_flight_q   <= in_flight_d;
      end
   end

   fetch_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .flush     (bus.redirect_valid),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (count)
   );

   assign bus.pm_addr     = fetch_pc_q;
   assign bus.pm_wdata    = '0;
   assign bus.pm_we       = 1'b0;
   assign bus.instr       = head.instr;
   assign bus.instr_pc    = head.pc;
   assign bus.instr_valid = instr_valid;

endmodule
